decode_scan_n: RTL and testbench
================================

Name: decode_scan_n

Overview:
- Parametrised, registered active-low 1-of-2^SEL_W decoder. It is the next-generation replacement for the fixed 3-to-8 enable-gated decoder.
- Adds a synchronous select latch and an auto-scan mode that walks the outputs, each held for a programmable dwell and followed by a blanking gap.
- Used as the chip-select generator in direct mode and as the row/digit strobe driver for multiplexed displays and keypads in scan mode.

Parameters:
- SEL_W, 3, select width; the block has NOUT = 2**SEL_W outputs (legal range 1..6).
- DWELL_W, 8, width of the dwell-length input.
- BLANK_CYC, 1, number of all-high cycles between scan steps (0 disables blanking).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- g1  in  1  enable, active-high.
- g2_n  in  1  enable, active-low.
- g3_n  in  1  enable, active-low.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- sel  in  SEL_W  direct-mode select.
- sel_le  in  1  select latch enable; sel is captured on the clk edge while this is 1.
- dwell  in  DWELL_W  scan dwell length; the active time is dwell+1 cycles.
- y_n  out  NOUT  decoded outputs, active-low, registered.
- cur_idx  out  SEL_W  index currently driven (latched sel, or scan index).
- wrap  out  1  one-cycle pulse when the scan index wraps.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: y_n all 1, cur_idx 0, wrap 0, select latch 0, FSM in IDLE, dwell counter 0, blank counter 0.
- Enable: en = g1 & ~g2_n & ~g3_n.
  - When en=0, y_n is all 1 on the next edge.
  - The scan FSM, counters and latch hold their values; sel_le still captures.
  - When en returns to 1, operation resumes from the held state with no restart.
- Latency: every y_n change appears 1 cycle after the cause.
  - In direct mode, a sel change appears 2 cycles later (latch edge, then output edge).
- Direct mode (mode=0):
  - y_n[i] = 0 if and only if i == latched sel and en=1.
  - cur_idx = latched sel.
  - The FSM is forced to IDLE.
- Scan FSM, states IDLE, DWELL, BLANK:
  - IDLE: when mode=1 and en=1, go to DWELL. Index = 0, and dwell is sampled into the down-counter.
  - DWELL: y_n[idx] = 0 and all other bits are 1. The counter decrements each cycle. At 0: if BLANK_CYC>0 go to BLANK, otherwise advance idx and reload from dwell.
  - BLANK: y_n all 1 for exactly BLANK_CYC cycles. Then advance idx, reload dwell, go to DWELL.
- Advance: idx = idx+1. At NOUT-1 it wraps to 0 and wrap pulses 1 for the cycle in which idx=0 is first driven.
- Dwell sampling: dwell is sampled only at reload. Mid-dwell changes have no effect until the next step.
- dwell=0 gives a 1-cycle active time per output (legal).
- Mode change:
  - 1 to 0: the FSM aborts to IDLE and y_n reflects the latched sel on the next edge.
  - 0 to 1: the scan always restarts at index 0.
- Simultaneous events:
  - sel_le during scan mode updates the latch only; the scan is unaffected.
  - mode=1 with en=0: the FSM stays in IDLE until en=1.
- Reset asserted mid-scan: all state returns to its reset value immediately (asynchronous). After deassertion the scan restarts from IDLE.
- Invariant: at most one y_n bit is low at any time.

Optional Feature:
- Macro: DECODE_SCAN_DIR_EN.
- Defined:
  - Adds input port scan_dir (1 bit). When scan_dir=1, the scan counts down: 0 to NOUT-1 (the wrap, which pulses wrap), then down to 0.
  - scan_dir is sampled only at each advance.
  - The scan start index is 0 for up and NOUT-1 for down.
- Undefined: the port is absent and the scan counts up only.

Decomposition:
- Shared package decode_pkg holds:
  - the scan_state_t enum (IDLE, DWELL, BLANK);
  - localparam function nout(sel_w);
  - the all-high output constant helper.
- Sub-module decode_core: a pure combinational active-low one-hot decoder (index, en to y_n), parametrised by SEL_W. It is instantiated once, and its output is registered in decode_scan_n.

Test Plan:
- Reset and direct mode:
  - Reset, g1=1, g2_n=0, g3_n=0, mode=0, sel=5, sel_le pulse → y_n=8'hDF two cycles after the sel_le edge, cur_idx=5.
  - g2_n=1 → y_n=8'hFF next cycle; g2_n=0 → 8'hDF again.
- Scan timing: mode=1, dwell=2, BLANK_CYC=1.
  - Expected pattern: y_n=8'hFE for 3 cycles, FF for 1, FD for 3, FF for 1, and so on.
  - After FF at idx7, FE reappears with wrap=1 for exactly one cycle. Full period = 32 cycles.
- Enable freeze: during scan at idx=3 mid-dwell, drop g1 for 4 cycles.
  - Expected: y_n=FF while g1=0.
  - On resume: 8'hF7 for the remaining dwell cycles, with no restart.
- dwell boundary and hold:
  - dwell=0 → each output is low for exactly 1 cycle.
  - Change dwell mid-DWELL from 0 to 5 → the new length applies from the next output only.
- Async reset mid-scan: assert rst_n=0 between clock edges at idx=6.
  - Expected: y_n=FF, cur_idx=0 immediately.
  - After release the scan restarts at idx0.
- With DECODE_SCAN_DIR_EN defined: scan_dir=1, dwell=0, BLANK_CYC=0.
  - Expected sequence from scan start: 7,6,…,0,7, with a wrap pulse when 7 is first driven after 0.
  - Invariant checked across all runs: popcount(~y_n) ≤ 1.

Source files
------------

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared scan states and helpers for the scanning decoder
// Contents: scan_state_t enum, nout() output-count function, all_high() mask helper.
package decode_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        BLANK = 2'd2
    } scan_state_t;

    localparam int MAX_NOUT = 64;

    function automatic int nout(input int sel_w);
        return 1 << sel_w;
    endfunction

    // Mask with the low n bits set; callers size-cast it to their output width.
    function automatic logic [MAX_NOUT-1:0] all_high(input int n);
        logic [MAX_NOUT-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_NOUT; i++) begin
            if (i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/decode_core.sv
// rtl/decode_core.sv - combinational active-low one-hot decoder
// Ports: idx (select index), en (output enable), y_n (active-low one-hot, all high when en=0).
module decode_core
    import decode_pkg::*;
#(
    parameter int SEL_W = 3,
    localparam int NOUT = nout(SEL_W)
) (
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [NOUT-1:0]  y_n
);

    always_comb begin
        y_n = NOUT'(all_high(NOUT));
        if (en) y_n[idx] = 1'b0;
    end

endmodule

// File: rtl/decode_scan_n.sv
// rtl/decode_scan_n.sv - registered active-low 1-of-2^SEL_W decoder with auto-scan
// Ports: clk, rst_n (async, active-low), g1/g2_n/g3_n enables, mode (0 direct, 1 scan),
//        sel/sel_le select latch, dwell (active time dwell+1 cycles), scan_dir (only with
//        DECODE_SCAN_DIR_EN defined), y_n decoded outputs, cur_idx driven index, wrap pulse.
module decode_scan_n
    import decode_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int DWELL_W   = 8,
    parameter int BLANK_CYC = 1,
    localparam int NOUT     = nout(SEL_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               g1,
    input  logic               g2_n,
    input  logic               g3_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               sel_le,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DECODE_SCAN_DIR_EN
    input  logic               scan_dir,
`endif
    output logic [NOUT-1:0]    y_n,
    output logic [SEL_W-1:0]   cur_idx,
    output logic               wrap
);

    // Blank counter runs BLANK_CYC-1 down to 0; keep at least one bit when blanking is off.
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam logic [NOUT-1:0] Y_OFF = NOUT'(all_high(NOUT));

    scan_state_t        state, state_nx;
    logic [SEL_W-1:0]   sel_q, idx, idx_nx, start_idx, step_idx, last_idx;
    logic [SEL_W-1:0]   drive_idx, cur_nx;
    logic [DWELL_W-1:0] cnt, cnt_nx;
    logic [BW-1:0]      bcnt, bcnt_nx;
    logic               en, down, advance, wrap_nx, drive_en;
    logic [NOUT-1:0]    y_dec;

    assign en = g1 & ~g2_n & ~g3_n;

`ifdef DECODE_SCAN_DIR_EN
    assign down = scan_dir;
`else
    assign down = 1'b0;
`endif

    // NOUT is a power of two, so plain modular add/subtract gives the wrap.
    assign start_idx = down ? '1 : '0;
    assign last_idx  = down ? '0 : '1;
    assign step_idx  = down ? idx - 1'b1 : idx + 1'b1;

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        bcnt_nx  = bcnt;
        advance  = 1'b0;
        wrap_nx  = 1'b0;
        if (!mode) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    state_nx = DWELL;
                    idx_nx   = start_idx;
                    cnt_nx   = dwell;
                end
                DWELL: begin
                    if (cnt == '0) begin
                        if (BLANK_CYC > 0) begin
                            state_nx = BLANK;
                            bcnt_nx  = BW'(BLANK_CYC - 1);
                        end else begin
                            advance = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                BLANK: begin
                    if (bcnt == '0) advance = 1'b1;
                    else            bcnt_nx = bcnt - 1'b1;
                end
                default: state_nx = IDLE;
            endcase
            if (advance) begin
                state_nx = DWELL;
                idx_nx   = step_idx;
                cnt_nx   = dwell;
                wrap_nx  = (idx == last_idx);
            end
        end
    end

    // Outputs are decoded from the next state so they land on the same edge as the FSM.
    always_comb begin
        if (mode) begin
            drive_idx = idx_nx;
            drive_en  = en & (state_nx == DWELL);
            cur_nx    = idx_nx;
        end else begin
            drive_idx = sel_q;
            drive_en  = en;
            cur_nx    = sel_q;
        end
    end

    decode_core #(.SEL_W(SEL_W)) u_core (
        .idx (drive_idx),
        .en  (drive_en),
        .y_n (y_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            cnt     <= '0;
            bcnt    <= '0;
            sel_q   <= '0;
            y_n     <= Y_OFF;
            cur_idx <= '0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            cnt     <= cnt_nx;
            bcnt    <= bcnt_nx;
            if (sel_le) sel_q <= sel;
            y_n     <= y_dec;
            cur_idx <= cur_nx;
            wrap    <= wrap_nx;
        end
    end

endmodule

// File: tb/tb_decode_scan_n.sv
// tb/tb_decode_scan_n.sv - scoreboard bench for decode_scan_n with a step-plan reference model
module tb_decode_scan_n;

    localparam int SEL_W     = 3;
    localparam int DWELL_W   = 8;
    localparam int BLANK_CYC = 1;
    localparam int NOUT      = 8;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               g1 = 1'b0, g2_n = 1'b1, g3_n = 1'b1;
    logic               mode = 1'b0, sel_le = 1'b0, scan_dir = 1'b0;
    logic [SEL_W-1:0]   sel = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [NOUT-1:0]    y_n;
    logic [SEL_W-1:0]   cur_idx;
    logic               wrap;

    always #5 clk = ~clk;

    decode_scan_n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .BLANK_CYC(BLANK_CYC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .g1      (g1),
        .g2_n    (g2_n),
        .g3_n    (g3_n),
        .mode    (mode),
        .sel     (sel),
        .sel_le  (sel_le),
        .dwell   (dwell),
`ifdef DECODE_SCAN_DIR_EN
        .scan_dir(scan_dir),
`endif
        .y_n     (y_n),
        .cur_idx (cur_idx),
        .wrap    (wrap)
    );

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        else passed++;
    endtask

    // Scoreboard entry: outputs required after the edge numbered 'due'.
    typedef struct {
        int               due;
        logic [NOUT-1:0]  y;
        logic [SEL_W-1:0] cur;
        logic             w;
    } exp_t;
    exp_t sb[$];

    // Reference model: each scan step is a plan of per-cycle entries
    // (dwell+1 lit cycles, then BLANK_CYC dark cycles); an enabled edge consumes one.
    typedef struct {
        logic             dark;
        logic [SEL_W-1:0] idx;
        logic             w;
    } plan_t;
    plan_t            plan[$];
    logic [SEL_W-1:0] m_sel = '0;
    logic [SEL_W-1:0] m_idx = '0;
    logic             m_scan = 1'b0;

    function automatic logic dir_now();
`ifdef DECODE_SCAN_DIR_EN
        return scan_dir;
`else
        return 1'b0;
`endif
    endfunction

    task automatic fill(input logic w);
        plan_t p;
        for (int k = 0; k <= int'(dwell); k++) begin
            p.dark = 1'b0; p.idx = m_idx; p.w = (k == 0) ? w : 1'b0;
            plan.push_back(p);
        end
        for (int k = 0; k < BLANK_CYC; k++) begin
            p.dark = 1'b1; p.idx = m_idx; p.w = 1'b0;
            plan.push_back(p);
        end
    endtask

    // Predict the outputs after the coming edge from the inputs currently applied.
    task automatic tick();
        exp_t  e;
        plan_t p;
        logic  en, w;
        en  = g1 & ~g2_n & ~g3_n;
        e.y = '1;
        e.w = 1'b0;
        if (!mode) begin
            m_scan = 1'b0; m_idx = '0; plan.delete();
            e.cur = m_sel;
            if (en) e.y[m_sel] = 1'b0;
        end else if (!en) begin
            e.cur = m_idx;
        end else begin
            if (!m_scan) begin
                m_scan = 1'b1;
                m_idx  = dir_now() ? '1 : '0;
                fill(1'b0);
            end else if (plan.size() == 0) begin
                w = dir_now() ? (m_idx == 0) : (m_idx == NOUT - 1);
                m_idx = dir_now() ? m_idx - 1 : m_idx + 1;
                fill(w);
            end
            p = plan.pop_front();
            if (!p.dark) e.y[p.idx] = 1'b0;
            e.cur = m_idx;
            e.w   = p.w;
        end
        if (sel_le) m_sel = sel;
        e.due = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic cycle();
        tick();
        @(negedge clk);
    endtask

    // Monitor: compare every entry whose edge has already happened.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("y_n", 32'(y_n), 32'(e.y));
            chk("cur_idx", 32'(cur_idx), 32'(e.cur));
            chk("wrap", 32'(wrap), 32'(e.w));
        end
        chk("at_most_one_low", 32'($countones(~y_n) <= 1), 32'd1);
    end

    task automatic restart_scan();
        mode = 1'b0; cycle();
        mode = 1'b1;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_y_n", 32'(y_n), 32'hFF);
        chk("rst_cur_idx", 32'(cur_idx), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        sb.delete(); plan.delete();
        m_sel = '0; m_idx = '0; m_scan = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    int guard;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_y_n", 32'(y_n), 32'hFF);
        chk("reset_cur_idx", 32'(cur_idx), 32'd0);
        rst_n = 1'b1;

        // Direct mode: latch 5, output two edges later.
        g1 = 1'b1; g2_n = 1'b0; g3_n = 1'b0; mode = 1'b0;
        sel = 3'd5; sel_le = 1'b1; cycle();
        sel_le = 1'b0; sel = 3'd2; cycle();
        chk("direct_sel5_y", 32'(y_n), 32'hDF);
        chk("direct_sel5_idx", 32'(cur_idx), 32'd5);
        g2_n = 1'b1; cycle();
        chk("direct_disabled", 32'(y_n), 32'hFF);
        g2_n = 1'b0; cycle(); cycle();

        // Scan timing, two full periods.
        dwell = 8'd2; mode = 1'b1;
        repeat (70) cycle();

        // Enable freeze at idx 3, mid-dwell.
        restart_scan();
        guard = 0;
        while (!(m_scan && m_idx == 3 && plan.size() == 2) && guard < 200) begin
            cycle(); guard++;
        end
        chk("freeze_reached", 32'(guard < 200), 32'd1);
        g1 = 1'b0; repeat (4) cycle();
        g1 = 1'b1; repeat (12) cycle();

        // dwell=0 then a change to 5 while scanning.
        dwell = 8'd0; restart_scan();
        repeat (20) cycle();
        dwell = 8'd5; repeat (30) cycle();

        // Async reset mid-scan at idx 6.
        dwell = 8'd1;
        guard = 0;
        while (!(m_scan && m_idx == 6) && guard < 200) begin
            cycle(); guard++;
        end
        chk("idx6_reached", 32'(guard < 200), 32'd1);
        async_reset();
        repeat (20) cycle();

`ifdef DECODE_SCAN_DIR_EN
        scan_dir = 1'b1; dwell = 8'd0; restart_scan();
        repeat (40) cycle();
        scan_dir = 1'b0;
`endif

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            g1     = ($urandom % 16) != 0;
            g2_n   = ($urandom % 20) == 0;
            g3_n   = ($urandom % 20) == 0;
            if (($urandom % 60) == 0) mode = ~mode;
            sel    = SEL_W'($urandom);
            sel_le = ($urandom % 4) == 0;
            if (($urandom % 10) == 0) dwell = DWELL_W'($urandom % 4);
            if (($urandom % 8) == 0) scan_dir = ~scan_dir;
            cycle();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
